bkm_step_driver: RTL and testbench

Stimulus driver for the BKM step verification bench: the producing end of the step-checker interface. Generates pseudo-random, reproducible BKM step operands (mode, format, iteration index, digits, control words u/v, data words X/Y) and sweeps the iteration index `n`. Feeds the DUT, the reference model and the checker. Collects checker error flags, aligned to the checker latency, into a pass/fail summary.

---
 rtl/bkm_tb_pkg.sv | 29 ++
 rtl/bkm_lfsr32.sv | 21 ++
 rtl/bkm_step_driver.sv | 179 +++++++++++++++++
 tb/tb_bkm_step_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bkm_tb_pkg.sv
// Shared definitions for the BKM step stimulus driver: FSM states, digit codes,
// LFSR polynomial and the raw-bits-to-digit mapping.
package bkm_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Raw code 10 has no digit meaning and is folded onto zero.
  function automatic logic [1:0] digit_map(input logic [1:0] raw);
    logic [1:0] d;
    case (raw)
      DIG_NEG: d = DIG_NEG;
      DIG_POS: d = DIG_POS;
      default: d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bkm_lfsr32.sv
// 32-bit Galois LFSR (right-shifting) with reset seed and advance enable.
module bkm_lfsr32
  import bkm_tb_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2016
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        adv,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= SEED;
    end else if (adv) begin
      state <= state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    end
  end

endmodule

// File: rtl/bkm_step_driver.sv
// BKM step stimulus driver: sweeps the iteration index, emits LFSR-derived operands
// and collects latency-aligned checker error flags into saturating counters.
module bkm_step_driver
  import bkm_tb_pkg::*;
#(
  parameter int unsigned WC      = 16,
  parameter int unsigned WD      = 64,
  parameter int unsigned LOG2N   = 6,
  parameter logic [31:0] SEED    = 32'hACE1_2016,
  parameter int unsigned CHK_LAT = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [1:0]       cfg_format,
  input  logic [LOG2N-1:0] cfg_n_last,
  input  logic [15:0]      cfg_vectors,
  input  logic             err_u,
  input  logic             err_v,
  input  logic             err_X,
  input  logic             err_Y,
  output logic             busy,
  output logic             done,
  output logic             tb_valid,
  output logic             tb_mode,
  output logic [1:0]       tb_format,
  output logic [LOG2N-1:0] tb_n,
  output logic [1:0]       tb_d_x_n,
  output logic [1:0]       tb_d_y_n,
  output logic [WC-1:0]    tb_u_n,
  output logic [WC-1:0]    tb_v_n,
  output logic [WD-1:0]    tb_X_n,
  output logic [WD-1:0]    tb_Y_n,
  output logic [15:0]      err_count,
  output logic [31:0]      vec_count
);

  state_t             state, state_nxt;
  logic [31:0]        s;
  logic [LOG2N-1:0]   nlast_q, nidx_q;
  logic [15:0]        vmax_q, vidx_q;
  logic [2:0]         dcnt_q;
  logic [CHK_LAT:0]   vpipe_q;

  logic               idle, emit, last_v, last_all, any_err;
  logic [15:0]        e_vmax, cur_v;
  logic [LOG2N-1:0]   e_nlast, cur_n;
  logic [WD-1:0]      x_w, y_w;

  bkm_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .arst_n(arst_n),
    .adv   (emit),
    .state (s)
  );

  // The first vector leaves on the start edge itself, so in IDLE the sweep
  // position and limits come straight from the cfg inputs.
  always_comb begin
    idle      = (state == ST_IDLE);
    e_vmax    = idle ? ((cfg_vectors == 16'd0) ? 16'd0 : cfg_vectors - 16'd1) : vmax_q;
    e_nlast   = idle ? cfg_n_last : nlast_q;
    cur_v     = idle ? '0 : vidx_q;
    cur_n     = idle ? '0 : nidx_q;
    last_v    = (cur_v == e_vmax);
    last_all  = last_v && (cur_n == e_nlast);
    emit      = 1'b0;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable && start) begin
          emit      = 1'b1;
          state_nxt = last_all ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (enable) begin
          emit = 1'b1;
          if (last_all) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable && (dcnt_q == 3'(CHK_LAT))) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    x_w = '0;
    y_w = '0;
    for (int unsigned k = 0; k < WD / 32; k++) begin
      if (((WD / 32 - 1 - k) % 2) == 0) begin
        x_w[k*32 +: 32] = s;
        y_w[k*32 +: 32] = ~s;
      end else begin
        x_w[k*32 +: 32] = ~s;
        y_w[k*32 +: 32] = s;
      end
    end
  end

  assign any_err = err_u | err_v | err_X | err_Y;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      tb_valid  <= 1'b0;
      tb_mode   <= 1'b0;
      tb_format <= '0;
      tb_n      <= '0;
      tb_d_x_n  <= '0;
      tb_d_y_n  <= '0;
      tb_u_n    <= '0;
      tb_v_n    <= '0;
      tb_X_n    <= '0;
      tb_Y_n    <= '0;
      nlast_q   <= '0;
      nidx_q    <= '0;
      vmax_q    <= '0;
      vidx_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      tb_valid <= emit;
      busy     <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done     <= (state_nxt == ST_DONE);
      if (idle && emit) begin
        tb_mode   <= cfg_mode;
        tb_format <= cfg_format;
        nlast_q   <= cfg_n_last;
        vmax_q    <= e_vmax;
      end
      if (emit) begin
        tb_n     <= cur_n;
        tb_d_x_n <= digit_map(s[1:0]);
        tb_d_y_n <= digit_map(s[3:2]);
        tb_u_n   <= s[WC-1:0];
        tb_v_n   <= s[31:32-WC];
        tb_X_n   <= x_w;
        tb_Y_n   <= y_w;
        vidx_q   <= last_v ? '0 : cur_v + 16'd1;
        nidx_q   <= last_v ? cur_n + 1'b1 : cur_n;
        dcnt_q   <= '0;
      end else if ((state == ST_DRAIN) && enable) begin
        dcnt_q <= dcnt_q + 3'd1;
      end
    end
  end

  // vpipe_q[0] mirrors tb_valid; bit CHK_LAT lines up with the checker flags.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vpipe_q   <= '0;
      err_count <= '0;
      vec_count <= '0;
    end else begin
      if (idle)        vpipe_q <= {{CHK_LAT{1'b0}}, emit};
      else if (enable) vpipe_q <= {vpipe_q[CHK_LAT-1:0], emit};

      if (idle && emit)                                   vec_count <= 32'd1;
      else if (emit && (vec_count != 32'hFFFF_FFFF))      vec_count <= vec_count + 32'd1;

      if (idle && emit)
        err_count <= '0;
      else if (enable && vpipe_q[CHK_LAT] && any_err && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_bkm_step_driver.sv
// Directed self-checking bench for bkm_step_driver.
module tb_bkm_step_driver;

  localparam int          CL   = 2;
  localparam logic [31:0] SEED = 32'hACE1_2016;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [1:0]  cfg_format = 2'b00;
  logic [5:0]  cfg_n_last = '0;
  logic [15:0] cfg_vectors = '0;
  logic        err_u = 1'b0, err_v = 1'b0, err_X = 1'b0, err_Y = 1'b0;
  logic        busy, done, tb_valid, tb_mode;
  logic [1:0]  tb_format, tb_d_x_n, tb_d_y_n;
  logic [5:0]  tb_n;
  logic [15:0] tb_u_n, tb_v_n, err_count;
  logic [63:0] tb_X_n, tb_Y_n;
  logic [31:0] vec_count;
  logic [163:0] obs;

  int checks = 0;
  int errors = 0;
  logic [31:0] ms;
  logic [15:0] su [8];

  bkm_step_driver #(
    .WC(16), .WD(64), .LOG2N(6), .SEED(SEED), .CHK_LAT(CL)
  ) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .start(start),
    .cfg_mode(cfg_mode), .cfg_format(cfg_format), .cfg_n_last(cfg_n_last),
    .cfg_vectors(cfg_vectors), .err_u(err_u), .err_v(err_v), .err_X(err_X),
    .err_Y(err_Y), .busy(busy), .done(done), .tb_valid(tb_valid),
    .tb_mode(tb_mode), .tb_format(tb_format), .tb_n(tb_n),
    .tb_d_x_n(tb_d_x_n), .tb_d_y_n(tb_d_y_n), .tb_u_n(tb_u_n), .tb_v_n(tb_v_n),
    .tb_X_n(tb_X_n), .tb_Y_n(tb_Y_n), .err_count(err_count), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  assign obs = {tb_d_x_n, tb_d_y_n, tb_u_n, tb_v_n, tb_X_n, tb_Y_n};

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [163:0] exp_vec(input logic [31:0] s);
    logic [1:0] dx, dy;
    dx = s[1:0];
    dy = s[3:2];
    if (dx == 2'b10) dx = 2'b00;
    if (dy == 2'b10) dy = 2'b00;
    return {dx, dy, s[15:0], s[31:16], s, ~s, ~s, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0; start = 1'b0; enable = 1'b1;
    err_u = 1'b0; err_v = 1'b0; err_X = 1'b0; err_Y = 1'b0;
    step(); step();
    arst_n = 1'b1;
    ms = SEED;
    step();
  endtask

  task automatic start_run(input logic [5:0] nl, input logic [15:0] nv,
                           input logic md, input logic [1:0] fm);
    cfg_n_last = nl; cfg_vectors = nv; cfg_mode = md; cfg_format = fm;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tb_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_valid_done: got %b%b expected 00", tb_valid, done); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_vec: got %h expected 0", obs); end
    checks++; if (err_count !== 16'd0 || vec_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got %h/%h expected 0/0", err_count, vec_count); end
    arst_n = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0 || tb_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b valid=%b expected 0/0", busy, tb_valid); end
  endtask

  task automatic test_single();
    int nvalid, done_at;
    logic [163:0] ev;
    do_reset();
    start_run(6'd0, 16'd0, 1'b0, 2'b00);
    checks++; if (tb_u_n !== 16'h2016) begin errors++; $display("FAIL single_u: got %h expected 2016", tb_u_n); end
    checks++; if (tb_d_x_n !== 2'b00) begin errors++; $display("FAIL single_dx: got %b expected 00", tb_d_x_n); end
    checks++; if (tb_d_y_n !== 2'b01) begin errors++; $display("FAIL single_dy: got %b expected 01", tb_d_y_n); end
    nvalid = 0; done_at = -1;
    for (int c = 0; c < 50 && done_at < 0; c++) begin
      if (c > 0) step();
      if (tb_valid === 1'b1) begin
        ev = exp_vec(ms); ms = lfsr_next(ms); nvalid++;
        checks++; if (obs !== ev) begin errors++; $display("FAIL single_vec: got %h expected %h", obs, ev); end
      end
      if (done === 1'b1) done_at = c;
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", nvalid); end
    checks++; if (done_at != CL + 1) begin errors++; $display("FAIL single_done_at: got %0d expected %0d", done_at, CL + 1); end
  endtask

  task automatic test_sweep();
    int nvalid, last, done_at;
    logic [163:0] ev;
    do_reset();
    start_run(6'd3, 16'd2, 1'b1, 2'b10);
    nvalid = 0; last = -1; done_at = -1;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      if (c > 0) step();
      if (tb_valid === 1'b1) begin
        ev = exp_vec(ms); ms = lfsr_next(ms);
        checks++; if (obs !== ev) begin errors++; $display("FAIL sweep_vec%0d: got %h expected %h", nvalid, obs, ev); end
        checks++; if (tb_n !== 6'(nvalid / 2)) begin errors++; $display("FAIL sweep_n%0d: got %0d expected %0d", nvalid, tb_n, nvalid / 2); end
        if (nvalid < 8) su[nvalid] = tb_u_n;
        nvalid++; last = c;
      end
      if (c == last + 1 && last == 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_drain_busy: got %b expected 1", busy); end
      end
      if (done === 1'b1) begin
        done_at = c;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_done_busy: got %b expected 0", busy); end
      end
    end
    checks++; if (nvalid != 8 || last != 7) begin errors++; $display("FAIL sweep_count: got %0d ending at %0d expected 8 ending at 7", nvalid, last); end
    checks++; if (done_at != last + CL + 1) begin errors++; $display("FAIL sweep_done_at: got %0d expected %0d", done_at, last + CL + 1); end
    checks++; if (tb_mode !== 1'b1 || tb_format !== 2'b10) begin errors++; $display("FAIL sweep_cfg: got %b/%b expected 1/10", tb_mode, tb_format); end
    checks++; if (vec_count !== 32'd8) begin errors++; $display("FAIL sweep_vec_count: got %0d expected 8", vec_count); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sweep_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_enable_toggle();
    int nvalid, done_at;
    logic en_edge;
    logic [163:0] ev;
    do_reset();
    start_run(6'd3, 16'd2, 1'b1, 2'b10);
    nvalid = 0; done_at = -1; en_edge = 1'b1;
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      if (c > 0) step();
      if (tb_valid === 1'b1) begin
        checks++; if (en_edge !== 1'b1) begin errors++; $display("FAIL toggle_valid_disabled: got valid=1 expected 0 at %0d", c); end
        ev = exp_vec(ms); ms = lfsr_next(ms);
        checks++; if (obs !== ev) begin errors++; $display("FAIL toggle_vec%0d: got %h expected %h", nvalid, obs, ev); end
        if (nvalid < 8) begin
          checks++; if (tb_u_n !== su[nvalid]) begin errors++; $display("FAIL toggle_u%0d: got %h expected %h", nvalid, tb_u_n, su[nvalid]); end
        end
        nvalid++;
      end
      if (done === 1'b1) done_at = c;
      enable = ~enable;
      en_edge = enable;
    end
    enable = 1'b1;
    checks++; if (done_at < 0) begin errors++; $display("FAIL toggle_timeout: got no done expected done"); end
    checks++; if (nvalid != 8) begin errors++; $display("FAIL toggle_count: got %0d expected 8", nvalid); end
    checks++; if (vec_count !== 32'd8) begin errors++; $display("FAIL toggle_vec_count: got %0d expected 8", vec_count); end
  endtask

  task automatic test_errors();
    int done_at;
    do_reset();
    start_run(6'd3, 16'd2, 1'b0, 2'b01);
    done_at = -1;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      if (c > 0) step();
      if (c == CL + 2) begin
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL err_before: got %0d expected 0", err_count); end
      end
      if (c == CL + 3) begin
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL err_after: got %0d expected 1", err_count); end
      end
      if (done === 1'b1) done_at = c;
      err_u = (c == 0);
      err_X = (c == 2 + CL);
    end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL err_at_done: got %0d expected 1", err_count); end
    err_v = 1'b1;
    step(); step(); step();
    err_v = 1'b0;
    step();
    checks++; if (err_count !== 16'd1 || vec_count !== 32'd8) begin errors++; $display("FAIL err_idle_hold: got %0d/%0d expected 1/8", err_count, vec_count); end
  endtask

  task automatic test_start_ignored();
    int nvalid, done_at;
    do_reset();
    start_run(6'd3, 16'd2, 1'b1, 2'b11);
    nvalid = 0; done_at = -1;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      if (c > 0) step();
      if (tb_valid === 1'b1) begin
        checks++; if (tb_n !== 6'(nvalid / 2) || tb_mode !== 1'b1) begin errors++; $display("FAIL ign_seq%0d: got n=%0d mode=%b expected n=%0d mode=1", nvalid, tb_n, tb_mode, nvalid / 2); end
        nvalid++;
      end
      if (done === 1'b1) done_at = c;
      start = (c == 2);
      if (c == 2) begin cfg_n_last = 6'd0; cfg_vectors = 16'd5; cfg_mode = 1'b0; end
    end
    start = 1'b0;
    checks++; if (nvalid != 8 || vec_count !== 32'd8) begin errors++; $display("FAIL ign_count: got %0d/%0d expected 8/8", nvalid, vec_count); end
  endtask

  task automatic test_reset_midrun();
    int seen;
    do_reset();
    start_run(6'd3, 16'd2, 1'b0, 2'b00);
    step(); step(); step();
    #1 arst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || tb_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags: got %b%b%b expected 000", busy, tb_valid, done); end
    checks++; if (obs !== '0 || tb_n !== 6'd0 || vec_count !== 32'd0) begin errors++; $display("FAIL abort_outputs: got %h/%0d/%0d expected 0/0/0", obs, tb_n, vec_count); end
    step();
    arst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    ms = SEED;
    start_run(6'd0, 16'd1, 1'b0, 2'b00);
    checks++; if (obs !== exp_vec(ms)) begin errors++; $display("FAIL abort_reseed: got %h expected %h", obs, exp_vec(ms)); end
    step(); step(); step(); step();
  endtask

  task automatic test_saturation();
    int done_at;
    do_reset();
    err_X = 1'b1;
    start_run(6'd63, 16'd1100, 1'b0, 2'b00);
    done_at = -1;
    for (int c = 0; c < 80000 && done_at < 0; c++) begin
      if (c > 0) step();
      if (c == CL + 1000) begin
        checks++; if (err_count !== 16'd1000) begin errors++; $display("FAIL sat_1000: got %0d expected 1000", err_count); end
      end
      if (c == CL + 65534) begin
        checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", err_count); end
      end
      if (c == CL + 65535) begin
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", err_count); end
      end
      if (done === 1'b1) done_at = c;
    end
    err_X = 1'b0;
    checks++; if (done_at != 70399 + CL + 1) begin errors++; $display("FAIL sat_done_at: got %0d expected %0d", done_at, 70399 + CL + 1); end
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h expected ffff", err_count); end
    checks++; if (vec_count !== 32'd70400) begin errors++; $display("FAIL sat_vec_count: got %0d expected 70400", vec_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_enable_toggle();
    test_errors();
    test_start_ignored();
    test_reset_midrun();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
